cdb_bram_ctrl: RTL and testbench
================================

Name: cdb_bram_ctrl

Overview:
- Parametrised backup-RAM cartridge controller for the Mega-CD BIOS mapper. Successor to the fixed-size RAM-cart instance.
- Size is runtime-selectable and bounded by a parameter. Adds a write-enable register and size-ID readback.
- Tracks dirty state with an idle timer and raises a save-request handshake, so the host MCU flushes BRAM to SD only after writes settle.
- Sits between the mapper CPU bus and the bram memory port.

Parameters:
- BRAM_AW, 18, word address width of the bram memory port. Maximum capacity is 2^BRAM_AW bytes, one byte per word.
- HOLD_W, 24, width of the idle-timer counter.
- HOLD_CYC, 24'd5000000, clock cycles with no write before save_req asserts.

Ports:
- clk  in  1  mapper clock
- rst  in  1  asynchronous reset, active high
- cpu_addr  in  24  CPU byte address
- cpu_dati  in  16  CPU write data
- cpu_oe  in  1  CPU read strobe, active low
- cpu_we_lo  in  1  CPU low-byte write strobe, active low
- cart_on  in  1  enables the whole cart window
- size_cfg  in  3  capacity select: 8KB << size_cfg
- cart_oe  out  1  drive map_do with cart_do
- cart_do  out  16  read data to the CPU
- mem_addr  out  BRAM_AW  bram word address
- mem_di  out  16  bram write data
- mem_do  in  16  bram read data, 1-cycle latency
- mem_oe  out  1  bram read enable
- mem_we_lo  out  1  bram low-byte write pulse
- dirty  out  1  unsaved data present
- save_req  out  1  flush request to host
- save_ack  in  1  host flush done

Behaviour:
- Reset values:
  - cart_oe=0, cart_do=16'hFFFF, mem_we_lo=0, mem_oe=0.
  - wren=0, dirty=0, save_req=0, timer=0, FSM=CLEAN.
  - mem_addr=0, mem_di=0.
- Regions: decoded only when cart_on=1, on cpu_addr[23:20].
  - ID: $400000-$5FFFFF.
  - RAM: $600000-$6FFFFF.
  - WE: $700000-$7FFFFF.
  - Outside these, or when cart_on=0, cart_oe=0.
- Effective size: sz = min(size_cfg, BRAM_AW-13). Word mask = 2^(13+sz)-1.
  - mem_addr = cpu_addr[BRAM_AW:1] & mask, so accesses wrap within the selected size.
- Reads:
  - cart_oe = region hit & !cpu_oe (combinational). mem_oe = RAM hit & !cpu_oe.
  - cart_do is registered one cycle after mem_do is valid.
    - RAM: {8'hFF, mem_do[7:0]}.
    - ID: {8'hFF, 5'd0, sz}.
    - WE: {8'hFF, 7'd0, wren}.
  - Data is valid 2 clk after cpu_oe falls.
- Writes: cpu_we_lo is registered; a falling edge gives a one-clk wstb.
  - WE region: wren <= cpu_dati[0].
  - RAM region with wren=1: mem_we_lo pulses 1 clk, mem_di = {8'h00, cpu_dati[7:0]}, and the dirty event fires.
  - RAM region with wren=0: ignored, no dirty event.
  - ID region: ignored.
- Flush FSM:
  - CLEAN: on a dirty event -> DIRTY, timer=0.
  - DIRTY: timer increments each clk and reloads to 0 on each dirty event. When timer==HOLD_CYC-1 -> REQ with save_req=1.
  - REQ: save_req held high. A dirty event sets pend=1. On save_ack=1, save_req=0; if pend=0 (and no dirty event this clk) -> CLEAN with dirty=0; otherwise -> DIRTY, timer=0, pend=0.
  - dirty=1 in DIRTY and REQ.
  - A dirty event coinciding with save_ack counts as pend: the write wins and the state returns to DIRTY.
  - save_ack outside REQ is ignored.
  - Timer saturates; it never wraps.
- Reset mid-operation:
  - Async clear of all state. A pending save_req drops immediately and dirty=0.
  - The host must treat the loss of save_req as a cancelled request.
- A size_cfg change takes effect on the next access; it does not touch the FSM.

Decomposition:
- Shared package cdb_pkg:
  - Region base constants: CDB_ID_BASE, CDB_RAM_BASE, CDB_WE_BASE.
  - CDB_MIN_AW=13.
  - Enum flush_st_t: CLEAN, DIRTY, REQ.
- One sub-module, cdb_flush_fsm: dirty-event in, save_ack in, save_req/dirty out, idle timer inside.
- Decode and datapath stay in cdb_bram_ctrl.

Test Plan:
1. Reset, cart_on=1, size_cfg=0; read $400001 -> cart_do=16'hFF00. Read $700001 -> 16'hFF00.
2. Write $6000 01=8'h5A with wren=0 -> no mem_we_lo, dirty=0. Write $700001=1, then repeat the write -> one mem_we_lo pulse, mem_addr=0, mem_di=16'h005A. Read back -> 16'hFF5A.
3. size_cfg=0 (mask 13 bits); write $604001 (word 0x2000) -> mem_addr=0 (wrap). size_cfg=7 with BRAM_AW=18 -> ID reads 16'hFF05.
4. HOLD_CYC=16: one write -> dirty=1; save_req rises exactly 16 clk after the write pulse. Pulse save_ack -> save_req=0, dirty=0.
5. HOLD_CYC=16: writes every 10 clk for 100 clk -> save_req stays 0 until 16 clk after the last write.
6. In REQ, write on the same clk as save_ack -> FSM=DIRTY, dirty=1, new save_req 16 clk later. Assert rst during REQ -> save_req=0, dirty=0 asynchronously.

Source files
------------

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared definitions for the Mega-CD backup-RAM cartridge controller.
//   - Region nibbles on cpu_addr[23:20] for the ID, RAM and write-enable windows
//   - Smallest selectable capacity (8KB words, 2^13)
//   - Flush FSM state encoding and decoded-region encoding
//   - cdb_decode(): maps cart_on and the top address nibble to a region
package cdb_pkg;

  // ID spans $400000-$5FFFFF, so only nibble bits [3:1] are compared for it.
  localparam logic [3:0] CDB_ID_BASE  = 4'h4;
  localparam logic [3:0] CDB_RAM_BASE = 4'h6;
  localparam logic [3:0] CDB_WE_BASE  = 4'h7;

  localparam int CDB_MIN_AW = 13;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    DIRTY = 2'd1,
    REQ   = 2'd2
  } flush_st_t;

  typedef enum logic [1:0] {
    RGN_NONE = 2'd0,
    RGN_ID   = 2'd1,
    RGN_RAM  = 2'd2,
    RGN_WE   = 2'd3
  } rgn_t;

  function automatic rgn_t cdb_decode(input logic on, input logic [3:0] nib);
    rgn_t r;
    r = RGN_NONE;
    if (on) begin
      if (nib[3:1] == CDB_ID_BASE[3:1]) r = RGN_ID;
      else if (nib == CDB_RAM_BASE)     r = RGN_RAM;
      else if (nib == CDB_WE_BASE)      r = RGN_WE;
    end
    return r;
  endfunction

endpackage

// File: rtl/cdb_flush_fsm.sv
// cdb_flush_fsm: dirty tracking and save-request handshake.
//   clk, rst    : clock, asynchronous active-high reset
//   dirty_ev_i  : one-clk pulse for each accepted BRAM write
//   save_ack_i  : host reports flush complete (only honoured in REQ)
//   save_req_o  : registered flush request, held until acknowledged
//   dirty_o     : registered, high while unsaved data exists (DIRTY/REQ)
// The idle timer restarts on every write; save_req rises HOLD_CYC clocks
// after the last write. Writes during REQ are remembered in pend_q so an
// acknowledge cannot discard them.
module cdb_flush_fsm
  import cdb_pkg::*;
#(
  parameter int                 HOLD_W   = 24,
  parameter logic [HOLD_W-1:0]  HOLD_CYC = HOLD_W'(5000000)
) (
  input  logic clk,
  input  logic rst,
  input  logic dirty_ev_i,
  input  logic save_ack_i,
  output logic save_req_o,
  output logic dirty_o
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_CYC - 1'b1;

  flush_st_t         st_q;
  logic [HOLD_W-1:0] timer_q;
  logic              pend_q;
  logic              save_req_q;
  logic              dirty_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= CLEAN;
      timer_q    <= '0;
      pend_q     <= 1'b0;
      save_req_q <= 1'b0;
      dirty_q    <= 1'b0;
    end else begin
      case (st_q)
        CLEAN: begin
          if (dirty_ev_i) begin
            st_q    <= DIRTY;
            timer_q <= '0;
            dirty_q <= 1'b1;
          end
        end
        DIRTY: begin
          // A write on the expiry clock wins: the request is postponed.
          if (dirty_ev_i) begin
            timer_q <= '0;
          end else if (timer_q == HOLD_LAST) begin
            st_q       <= REQ;
            save_req_q <= 1'b1;
          end else if (timer_q != {HOLD_W{1'b1}}) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        REQ: begin
          if (save_ack_i) begin
            save_req_q <= 1'b0;
            pend_q     <= 1'b0;
            timer_q    <= '0;
            if (pend_q || dirty_ev_i) begin
              st_q <= DIRTY;
            end else begin
              st_q    <= CLEAN;
              dirty_q <= 1'b0;
            end
          end else if (dirty_ev_i) begin
            pend_q <= 1'b1;
          end
        end
        default: begin
          st_q       <= CLEAN;
          timer_q    <= '0;
          pend_q     <= 1'b0;
          save_req_q <= 1'b0;
          dirty_q    <= 1'b0;
        end
      endcase
    end
  end

  assign save_req_o = save_req_q;
  assign dirty_o    = dirty_q;

endmodule

// File: rtl/cdb_bram_ctrl.sv
// cdb_bram_ctrl: backup-RAM cartridge controller for the Mega-CD BIOS mapper.
//   CPU side : cpu_addr/cpu_dati, cpu_oe and cpu_we_lo (active low), cart_on
//   Config   : size_cfg selects 8KB << size_cfg, clipped to the BRAM size
//   Read     : cart_oe (combinational), cart_do (registered, 2 clk after oe)
//   BRAM     : mem_addr/mem_di/mem_we_lo registered, mem_oe combinational,
//              mem_do returned one clock after the read
//   Flush    : dirty/save_req towards host, save_ack from host
// Windows: ID $400000-$5FFFFF, RAM $600000-$6FFFFF, WE $700000-$7FFFFF.
// Only the low data byte is stored; reads return 8'hFF in the high byte.
module cdb_bram_ctrl
  import cdb_pkg::*;
#(
  parameter int                BRAM_AW  = 18,
  parameter int                HOLD_W   = 24,
  parameter logic [HOLD_W-1:0] HOLD_CYC = HOLD_W'(5000000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [23:0]        cpu_addr,
  input  logic [15:0]        cpu_dati,
  input  logic               cpu_oe,
  input  logic               cpu_we_lo,
  input  logic               cart_on,
  input  logic [2:0]         size_cfg,
  output logic               cart_oe,
  output logic [15:0]        cart_do,
  output logic [BRAM_AW-1:0] mem_addr,
  output logic [15:0]        mem_di,
  input  logic [15:0]        mem_do,
  output logic               mem_oe,
  output logic               mem_we_lo,
  output logic               dirty,
  output logic               save_req,
  input  logic               save_ack
);

  localparam int               SZ_SPAN = BRAM_AW - CDB_MIN_AW;
  localparam logic [2:0]       SZ_MAX  = (SZ_SPAN > 7) ? 3'd7 : 3'(SZ_SPAN);

  // Word mask for 2^(13+s) words; saturates to all ones at full BRAM size.
  function automatic logic [BRAM_AW-1:0] word_mask(input logic [2:0] s);
    logic [BRAM_AW-1:0] m;
    m = '0;
    for (int i = 0; i < BRAM_AW; i++) begin
      if (i < CDB_MIN_AW + int'(s)) m[i] = 1'b1;
    end
    return m;
  endfunction

  logic [2:0]         sz;
  rgn_t               rgn;
  logic               rd_req;
  logic               wstb;
  logic               dirty_ev;

  logic               we_q;
  logic               wren_q;
  logic               mem_we_lo_q;
  logic [15:0]        mem_di_q;
  logic [BRAM_AW-1:0] mem_addr_q;
  logic               vld_p0_q;
  rgn_t               rgn_p0_q;
  logic [15:0]        cart_do_q;

  assign sz       = (size_cfg > SZ_MAX) ? SZ_MAX : size_cfg;
  assign rgn      = cdb_decode(cart_on, cpu_addr[23:20]);
  assign rd_req   = (rgn != RGN_NONE) && !cpu_oe;
  assign cart_oe  = rd_req;
  assign mem_oe   = (rgn == RGN_RAM) && !cpu_oe;

  // Falling edge of the registered write strobe gives a single-clk pulse.
  assign wstb     = we_q && !cpu_we_lo;
  assign dirty_ev = wstb && (rgn == RGN_RAM) && wren_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q        <= 1'b1;
      wren_q      <= 1'b0;
      mem_we_lo_q <= 1'b0;
      mem_di_q    <= '0;
      mem_addr_q  <= '0;
      vld_p0_q    <= 1'b0;
      rgn_p0_q    <= RGN_NONE;
      cart_do_q   <= 16'hFFFF;
    end else begin
      we_q        <= cpu_we_lo;
      mem_we_lo_q <= dirty_ev;
      if (dirty_ev) mem_di_q <= {8'h00, cpu_dati[7:0]};
      if (wstb && rgn == RGN_WE) wren_q <= cpu_dati[0];

      // Stage p0: address to BRAM, read request and region captured
      mem_addr_q <= cpu_addr[BRAM_AW:1] & word_mask(sz);
      vld_p0_q   <= rd_req;
      rgn_p0_q   <= rgn;

      // Stage p1: BRAM data valid, form the CPU read word
      if (vld_p0_q) begin
        case (rgn_p0_q)
          RGN_RAM: cart_do_q <= {8'hFF, mem_do[7:0]};
          RGN_ID:  cart_do_q <= {8'hFF, 5'd0, sz};
          RGN_WE:  cart_do_q <= {8'hFF, 7'd0, wren_q};
          default: cart_do_q <= 16'hFFFF;
        endcase
      end else begin
        cart_do_q <= 16'hFFFF;
      end
    end
  end

  assign cart_do   = cart_do_q;
  assign mem_addr  = mem_addr_q;
  assign mem_di    = mem_di_q;
  assign mem_we_lo = mem_we_lo_q;

  cdb_flush_fsm #(
    .HOLD_W   (HOLD_W),
    .HOLD_CYC (HOLD_CYC)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .dirty_ev_i (dirty_ev),
    .save_ack_i (save_ack),
    .save_req_o (save_req),
    .dirty_o    (dirty)
  );

  // Address/data bits outside the decoded byte lane and BRAM range.
  logic unused_bits;
  assign unused_bits = ^{cpu_addr, cpu_dati[15:8], mem_do[15:8]};

endmodule

// File: tb/tb_cdb_bram_ctrl.sv
module tb_cdb_bram_ctrl;

  localparam int BRAM_AW = 18;

  logic               clk = 1'b0;
  logic               rst;
  logic [23:0]        cpu_addr;
  logic [15:0]        cpu_dati;
  logic               cpu_oe;
  logic               cpu_we_lo;
  logic               cart_on;
  logic [2:0]         size_cfg;
  logic               cart_oe;
  logic [15:0]        cart_do;
  logic [BRAM_AW-1:0] mem_addr;
  logic [15:0]        mem_di;
  logic [15:0]        mem_do;
  logic               mem_oe;
  logic               mem_we_lo;
  logic               dirty;
  logic               save_req;
  logic               save_ack;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [15:0] rd;

  logic [7:0] bram [0:(1<<BRAM_AW)-1];

  always #5 clk = ~clk;

  cdb_bram_ctrl #(
    .BRAM_AW  (BRAM_AW),
    .HOLD_W   (24),
    .HOLD_CYC (24'd16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_dati  (cpu_dati),
    .cpu_oe    (cpu_oe),
    .cpu_we_lo (cpu_we_lo),
    .cart_on   (cart_on),
    .size_cfg  (size_cfg),
    .cart_oe   (cart_oe),
    .cart_do   (cart_do),
    .mem_addr  (mem_addr),
    .mem_di    (mem_di),
    .mem_do    (mem_do),
    .mem_oe    (mem_oe),
    .mem_we_lo (mem_we_lo),
    .dirty     (dirty),
    .save_req  (save_req),
    .save_ack  (save_ack)
  );

  // BRAM model: one-cycle read latency, low-byte write
  always @(posedge clk) begin
    if (mem_we_lo === 1'b1) begin
      bram[mem_addr] <= mem_di[7:0];
      we_cnt <= we_cnt + 1;
    end
    if (mem_oe === 1'b1) mem_do <= {8'h00, bram[mem_addr]};
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the clock edge on which the write strobe is taken.
  task automatic cpu_write(input logic [23:0] a, input logic [15:0] d);
    cpu_addr = a;
    cpu_dati = d;
    tick(1);
    cpu_we_lo = 1'b0;
    tick(1);
    cpu_we_lo = 1'b1;
  endtask

  task automatic cpu_read(input logic [23:0] a, output logic [15:0] d);
    cpu_addr = a;
    tick(1);
    cpu_oe = 1'b0;
    tick(2);
    d = cart_do;
    cpu_oe = 1'b1;
    tick(1);
  endtask

  initial begin
    rst = 1'b1; cpu_addr = '0; cpu_dati = '0; cpu_oe = 1'b1; cpu_we_lo = 1'b1;
    cart_on = 1'b1; size_cfg = 3'd0; save_ack = 1'b0; mem_do = '0;
    tick(3);
    chk("rst_cart_oe",   cart_oe,   0);
    chk("rst_cart_do",   cart_do,   16'hFFFF);
    chk("rst_mem_we",    mem_we_lo, 0);
    chk("rst_mem_oe",    mem_oe,    0);
    chk("rst_dirty",     dirty,     0);
    chk("rst_save_req",  save_req,  0);
    chk("rst_mem_addr",  mem_addr,  0);
    chk("rst_mem_di",    mem_di,    0);
    rst = 1'b0;
    tick(2);

    // ID and WE readback after reset
    cpu_read(24'h400001, rd); chk("id_sz0", rd, 16'hFF00);
    cpu_read(24'h700001, rd); chk("we_rd0", rd, 16'hFF00);

    // cart_oe decode
    cpu_addr = 24'h600001; cpu_oe = 1'b0; #1;
    chk("oe_ram_hit", cart_oe, 1);
    chk("mem_oe_ram", mem_oe, 1);
    cpu_addr = 24'h000001; #1;
    chk("oe_outside", cart_oe, 0);
    cpu_addr = 24'h500001; #1;
    chk("oe_id_hi", cart_oe, 1);
    chk("mem_oe_id", mem_oe, 0);
    cart_on = 1'b0; cpu_addr = 24'h600001; #1;
    chk("oe_cart_off", cart_oe, 0);
    cart_on = 1'b1; cpu_oe = 1'b1;
    tick(1);

    // Write with wren=0 is dropped
    cpu_write(24'h600001, 16'h335A);
    chk("wr_off_pulse", mem_we_lo, 0);
    tick(1);
    chk("wr_off_cnt", we_cnt, 0);
    chk("wr_off_dirty", dirty, 0);

    // Enable writes, then the RAM write goes through
    cpu_write(24'h700001, 16'h0001);
    tick(1);
    cpu_read(24'h700001, rd); chk("we_rd1", rd, 16'hFF01);
    cpu_write(24'h600001, 16'h335A);
    chk("wr_pulse",    mem_we_lo, 1);
    chk("wr_addr",     mem_addr,  0);
    chk("wr_di",       mem_di,    16'h005A);
    chk("wr_dirty",    dirty,     1);
    tick(1);
    chk("wr_pulse_end", mem_we_lo, 0);
    chk("wr_cnt",       we_cnt,    1);
    cpu_read(24'h600001, rd); chk("rd_5a", rd, 16'hFF5A);

    // 8KB size: word 0x2000 wraps to word 0
    cpu_write(24'h604001, 16'h00A5);
    chk("wrap_addr", mem_addr, 0);
    chk("wrap_di",   mem_di,   16'h00A5);
    tick(1);
    cpu_read(24'h600001, rd); chk("wrap_rd", rd, 16'hFFA5);
    size_cfg = 3'd7;
    cpu_read(24'h400001, rd); chk("id_sz_clip", rd, 16'hFF05);
    size_cfg = 3'd0;

    // Drain pending dirty state before timing checks
    for (int i = 0; i < 40 && save_req !== 1'b1; i++) tick(1);
    chk("drain_req", save_req, 1);
    save_ack = 1'b1; tick(1); save_ack = 1'b0;
    chk("drain_dirty", dirty, 0);

    // Single write: save_req exactly 16 clk after the pulse
    cpu_write(24'h600003, 16'h0011);
    chk("t4_dirty", dirty, 1);
    chk("t4_req0",  save_req, 0);
    tick(15); chk("t4_req15", save_req, 0);
    tick(1);  chk("t4_req16", save_req, 1);
    chk("t4_dirty_req", dirty, 1);
    tick(3);  chk("t4_req_hold", save_req, 1);
    save_ack = 1'b1; tick(1); save_ack = 1'b0;
    chk("t4_ack_req",   save_req, 0);
    chk("t4_ack_dirty", dirty, 0);
    save_ack = 1'b1; tick(1); save_ack = 1'b0;
    chk("t4_ack_idle", dirty, 0);

    // Writes every 10 clk postpone the request
    for (int k = 0; k < 10; k++) begin
      cpu_write(24'h600005, 16'(k));
      chk("t5_req_busy", save_req, 0);
      if (k < 9) tick(8);
    end
    tick(15); chk("t5_req15", save_req, 0);
    tick(1);  chk("t5_req16", save_req, 1);

    // Write coinciding with save_ack returns to DIRTY
    cpu_addr = 24'h600007; cpu_dati = 16'h0077;
    tick(1);
    cpu_we_lo = 1'b0; save_ack = 1'b1;
    tick(1);
    cpu_we_lo = 1'b1; save_ack = 1'b0;
    chk("t6_req_drop", save_req, 0);
    chk("t6_dirty",    dirty,    1);
    tick(15); chk("t6_req15", save_req, 0);
    tick(1);  chk("t6_req16", save_req, 1);

    // Async reset during REQ
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_req",   save_req, 0);
    chk("t6_rst_dirty", dirty,    0);
    tick(1);
    rst = 1'b0;
    tick(1);
    cpu_read(24'h700001, rd); chk("t6_rst_wren", rd, 16'hFF00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
